program_counter: RTL and testbench

- Architectural PC register for the single-cycle RV32 core.
- Captures the next-PC value computed by the surrounding PC logic (PC+4, branch or jump target) on each rising clock edge.
- Presents the current PC to instruction memory and to the branch/jump adders.
- Adds stall hold, alignment enforcement and a previous-PC output for debug.

---
 rtl/program_counter.sv | 94 +++++++++
 tb/tb_program_counter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/program_counter.sv
// ---------------------------------------------------------------------------
// program_counter
//   Architectural PC register for the single-cycle RV32 core. It captures the
//   next-PC value from the PC-select logic on each rising edge of clk. It
//   holds when stalled and forces instruction alignment on every load. It also
//   keeps the previous PC for debug.
//
// Parameters
//   XLEN         PC width in bits
//   RESET_VECTOR PC value forced during reset (must be 2**ALIGN_BITS aligned)
//   ALIGN_BITS   number of low PC bits forced to zero (0 disables alignment)
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous reset, active low
//   pc_en        1 = load PC_next_in, 0 = hold (stall)
//   PC_next_in   next PC from the PC-select logic
//   PC_out       current PC (instruction memory address)
//   PC_prev_out  PC value held before the most recent update
//   pc_valid     0 in reset, 1 from the first edge after reset release
//   misalign_err one-cycle pulse: the last loaded PC_next_in was misaligned
//
// Optional build macro PC_TRACE_EN (simulation only):
//   The design prints every enabled update and adds an extra MISALIGNED line
//   when the loaded value was misaligned. It also keeps an internal update
//   counter, update_count, that can be read hierarchically. Ports and
//   behaviour are the same with or without the macro.
// ---------------------------------------------------------------------------
module program_counter #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int unsigned     ALIGN_BITS   = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            pc_en,
   input  logic [XLEN-1:0] PC_next_in,
   output logic [XLEN-1:0] PC_out,
   output logic [XLEN-1:0] PC_prev_out,
   output logic            pc_valid,
   output logic            misalign_err
);

   // The mask is built by shifting, so ALIGN_BITS = 0 gives an all-zero mask.
   // A direct [ALIGN_BITS-1:0] slice would become an illegal [-1:0] range.
   localparam logic [XLEN-1:0] LOW_MASK =
      ({{(XLEN-1){1'b0}}, 1'b1} << ALIGN_BITS) - {{(XLEN-1){1'b0}}, 1'b1};

   logic [XLEN-1:0] pc_aligned;
   logic            next_misaligned;

   assign pc_aligned      = PC_next_in & ~LOW_MASK;
   assign next_misaligned = |(PC_next_in & LOW_MASK);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         PC_out       <= RESET_VECTOR;
         PC_prev_out  <= RESET_VECTOR;
         pc_valid     <= 1'b0;
         misalign_err <= 1'b0;
      end else begin
         pc_valid <= 1'b1;
         if (pc_en) begin
            PC_prev_out  <= PC_out;
            PC_out       <= pc_aligned;
            misalign_err <= next_misaligned;
         end else begin
            misalign_err <= 1'b0;
         end
      end
   end

`ifdef PC_TRACE_EN
   logic [XLEN-1:0] update_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         update_count <= '0;
      end else if (pc_en) begin
         update_count <= update_count + {{(XLEN-1){1'b0}}, 1'b1};
      end
   end

   always @(posedge clk) begin
      if (reset && pc_en) begin
         $display("%0t program_counter: pc %h -> %h", $time, PC_out, pc_aligned);
         if (next_misaligned) begin
            $display("%0t program_counter: MISALIGNED next pc %h", $time, PC_next_in);
         end
      end
   end
`endif

endmodule

// File: tb/tb_program_counter.sv
// ---------------------------------------------------------------------------
// tb_program_counter
//   Self-checking bench for program_counter. It runs directed cases first,
//   then randomized updates, stalls and asynchronous resets. Each result is
//   compared against a reference model written from the PC rules.
// ---------------------------------------------------------------------------
module tb_program_counter;

   localparam int unsigned XLEN = 32;
   localparam logic [31:0] RV   = 32'h0000_0000;

   logic        clk;
   logic        reset;
   logic        pc_en;
   logic [31:0] PC_next_in;
   logic [31:0] PC_out;
   logic [31:0] PC_prev_out;
   logic        pc_valid;
   logic        misalign_err;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   logic [31:0] m_pc, m_prev;
   logic        m_valid, m_mis;

   program_counter #(.XLEN(XLEN), .RESET_VECTOR(RV), .ALIGN_BITS(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .pc_en       (pc_en),
      .PC_next_in  (PC_next_in),
      .PC_out      (PC_out),
      .PC_prev_out (PC_prev_out),
      .pc_valid    (pc_valid),
      .misalign_err(misalign_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".pc"},    PC_out,      m_pc);
      check({tag, ".prev"},  PC_prev_out, m_prev);
      check({tag, ".valid"}, 32'(pc_valid),     32'(m_valid));
      check({tag, ".mis"},   32'(misalign_err), 32'(m_mis));
   endtask

   task automatic model_reset();
      m_pc    = RV;
      m_prev  = RV;
      m_valid = 1'b0;
      m_mis   = 1'b0;
   endtask

   // A load keeps the word address: drop the remainder modulo 4.
   task automatic model_edge(input logic en, input logic [31:0] nxt);
      if (reset) begin
         m_valid = 1'b1;
         if (en) begin
            m_prev = m_pc;
            m_pc   = nxt - (nxt % 32'd4);
            m_mis  = (nxt % 32'd4) != 32'd0;
         end else begin
            m_mis  = 1'b0;
         end
      end
   endtask

   // Call away from the edge. The next-PC input must not reach PC_out before
   // the edge. After the edge the outputs follow the model.
   task automatic step(input logic en, input logic [31:0] nxt, input string tag);
      pc_en      = en;
      PC_next_in = nxt;
      #1;
      check({tag, ".nocomb"}, PC_out, m_pc);
      @(posedge clk);
      model_edge(en, nxt);
      #1;
      check_all(tag);
   endtask

   // Reset falls between edges. The outputs must clear without a clock edge.
   task automatic async_reset(input string tag);
      reset = 1'b0;
      #2;
      model_reset();
      check_all(tag);
      repeat (2) begin
         pc_en      = 1'b1;
         PC_next_in = $urandom;
         @(posedge clk);
         #1;
         check_all({tag, ".held"});
      end
      reset = 1'b1;
   endtask

   initial begin
      reset      = 1'b0;
      pc_en      = 1'b1;
      PC_next_in = 32'h0000_0040;
      model_reset();
      #1;
      check_all("rst_noclk");
      repeat (3) @(posedge clk);
      #1;
      check_all("rst_hold");
      reset = 1'b1;

      step(1'b1, 32'd4,  "seq4");
      step(1'b1, 32'd8,  "seq8");
      step(1'b1, 32'd12, "seq12");

      step(1'b0, 32'h100, "stall1");
      step(1'b0, 32'h100, "stall2");
      step(1'b1, 32'h100, "load100");

      step(1'b1, 32'h106, "mis106");
      step(1'b1, 32'h108, "al108");
      step(1'b1, 32'h106, "mis106b");
      check("pc104", PC_out, 32'h104);
      async_reset("midrst");

      step(1'b1, 32'hFFFF_FFFC, "wrap_hi");
      step(1'b1, 32'h0000_0000, "wrap_lo");
      check("wrap_prev", PC_prev_out, 32'hFFFF_FFFC);

      for (int i = 0; i < 400; i++) begin
         logic        en;
         logic [31:0] nxt;
         en  = ($urandom_range(0, 3) != 0);
         nxt = $urandom;
         if ($urandom_range(0, 3) != 0) nxt = nxt & 32'hFFFF_FFFC;
         if ($urandom_range(0, 39) == 0) begin
            async_reset("rnd_rst");
         end else begin
            step(en, nxt, "rnd");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
